// File: rtl/timer_ctrl_master.sv
// Avalon-MM master sequencing the interval-timer slave: program/start, stop, snapshot, irq service.
// Latency: one state per cycle, all bus outputs registered; strobes arriving while busy are dropped, not queued.
module timer_ctrl_master #(
    parameter int TICK_W     = 16,
    parameter bit AUTO_CLEAR = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_start,
    input  logic [31:0]       cmd_period,
    input  logic              cmd_continuous,
    input  logic              cmd_stop,
    input  logic              cmd_snap,
    output logic              busy,
    output logic              running,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic              irq_pending,
    output logic [31:0]       snap_value,
    output logic              snap_valid,
    output logic [2:0]        av_address,
    output logic              av_chipselect,
    output logic              av_write_n,
    output logic [15:0]       av_writedata,
    input  logic [15:0]       av_readdata,
    input  logic              timer_irq
);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_PL, S_WR_PH, S_GAP, S_WR_CTL, S_CLR_ST,
        S_WR_STOP, S_WR_SNAP, S_RD_SL, S_RD_SH, S_RD_END
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] period_hi;
    logic        cont;
    logic [15:0] snap_lo;

    logic        nxt_cs;
    logic        nxt_wn;
    logic [2:0]  nxt_addr;
    logic [15:0] nxt_data;

    assign busy = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (irq_pending && (AUTO_CLEAR != 1'b0)) state_nxt = S_CLR_ST;
                else if (cmd_stop)                       state_nxt = S_WR_STOP;
                else if (cmd_snap)                       state_nxt = S_WR_SNAP;
                else if (cmd_start)                      state_nxt = S_WR_PL;
            end
            S_WR_PL:   state_nxt = S_WR_PH;
            S_WR_PH:   state_nxt = S_GAP;
            S_GAP:     state_nxt = S_WR_CTL;
            S_WR_CTL:  state_nxt = S_IDLE;
            S_CLR_ST:  state_nxt = S_IDLE;
            S_WR_STOP: state_nxt = S_IDLE;
            S_WR_SNAP: state_nxt = S_RD_SL;
            S_RD_SL:   state_nxt = S_RD_SH;
            S_RD_SH:   state_nxt = S_RD_END;
            S_RD_END:  state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Bus values are decoded from the next state so the registered av_* line up with the state they belong to.
    always_comb begin
        nxt_cs   = 1'b0;
        nxt_wn   = 1'b1;
        nxt_addr = 3'd0;
        nxt_data = 16'h0000;
        case (state_nxt)
            S_WR_PL: begin
                nxt_cs   = 1'b1;
                nxt_wn   = 1'b0;
                nxt_addr = 3'd2;
                nxt_data = cmd_period[15:0];
            end
            S_WR_PH: begin
                nxt_cs   = 1'b1;
                nxt_wn   = 1'b0;
                nxt_addr = 3'd3;
                nxt_data = period_hi;
            end
            S_WR_CTL: begin
                nxt_cs   = 1'b1;
                nxt_wn   = 1'b0;
                nxt_addr = 3'd1;
                nxt_data = {12'h000, 1'b0, 1'b1, cont, 1'b1};
            end
            S_CLR_ST: begin
                nxt_cs   = 1'b1;
                nxt_wn   = 1'b0;
                nxt_addr = 3'd0;
            end
            S_WR_STOP: begin
                nxt_cs   = 1'b1;
                nxt_wn   = 1'b0;
                nxt_addr = 3'd1;
                nxt_data = 16'h0008;
            end
            S_WR_SNAP: begin
                nxt_cs   = 1'b1;
                nxt_wn   = 1'b0;
                nxt_addr = 3'd4;
            end
            S_RD_SL: begin
                nxt_cs   = 1'b1;
                nxt_addr = 3'd4;
            end
            S_RD_SH: begin
                nxt_cs   = 1'b1;
                nxt_addr = 3'd5;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            period_hi     <= 16'h0000;
            cont          <= 1'b0;
            snap_lo       <= 16'h0000;
            running       <= 1'b0;
            tick          <= 1'b0;
            tick_count    <= '0;
            irq_pending   <= 1'b0;
            snap_value    <= 32'h0000_0000;
            snap_valid    <= 1'b0;
            av_chipselect <= 1'b0;
            av_write_n    <= 1'b1;
            av_address    <= 3'd0;
            av_writedata  <= 16'h0000;
        end else begin
            state         <= state_nxt;
            av_chipselect <= nxt_cs;
            av_write_n    <= nxt_wn;
            av_address    <= nxt_addr;
            av_writedata  <= nxt_data;

            if (state == S_IDLE && state_nxt == S_WR_PL) begin
                period_hi <= cmd_period[31:16];
                cont      <= cmd_continuous;
            end

            // The slave clears status on the CLR_ST edge, so drop the stale copy to avoid a second service.
            irq_pending <= (state == S_CLR_ST) ? 1'b0 : timer_irq;

            tick <= (state_nxt == S_CLR_ST);
            if (state_nxt == S_CLR_ST)
                tick_count <= tick_count + TICK_W'(1);

            if (state_nxt == S_WR_CTL)
                running <= 1'b1;
            else if (state_nxt == S_WR_STOP)
                running <= 1'b0;
            else if (state_nxt == S_CLR_ST && !cont)
                running <= 1'b0;

            if (state == S_RD_SH)
                snap_lo <= av_readdata;
            if (state == S_RD_END) begin
                snap_value <= {av_readdata, snap_lo};
                snap_valid <= 1'b1;
            end else begin
                snap_valid <= 1'b0;
            end
        end
    end

endmodule
